// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - responder for control-unit memory handshake onto a req/gnt/rvalid bus
// Optional watchdog: define MAU_TIMEOUT_EN to abandon REQ/WAIT_R after TIMEOUT_CYCLES cycles.
module memory_access_unit #(
    parameter int          MEM_ADDR_W     = 30,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memory_read_enable,
    input  logic                  memory_write_enable,
    input  logic [31:0]           memory_address,
    input  logic [31:0]           memory_write_data,
    output logic [31:0]           memory_read_data,
    output logic                  memory_read_data_valid,
    output logic                  memory_write_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  mau_error,
    output logic                  mau_busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic        any_request;
    logic        bad_request;
    logic        good_request;
    logic        timeout;
    logic        set_error;
    logic        pulse_rd_next;
    logic        pulse_wr_next;
    logic        load_rdata;
    logic [31:0] rdata_next;

    // A conflicting or misaligned request is answered immediately without touching the bus
    assign any_request  = memory_read_enable | memory_write_enable;
    assign bad_request  = any_request &
                          ((memory_read_enable & memory_write_enable) | (memory_address[1:0] != 2'b00));
    assign good_request = any_request & ~bad_request;

`ifdef MAU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wait_count;

    // Watchdog: restarts on every state change, counts cycles spent waiting on the bus
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_count <= '0;
        end else if (state != next_state) begin
            wait_count <= '0;
        end else if (state == REQ || state == WAIT_R) begin
            wait_count <= wait_count + 16'd1;
        end
    end

    assign timeout = (state == REQ || state == WAIT_R) && (wait_count == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a real bus completion wins over a coincident watchdog expiry
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bad_request) begin
                    next_state = RESP;
                end else if (good_request) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    next_state = mem_we ? RESP : WAIT_R;
                end else if (timeout) begin
                    next_state = RESP;
                end
            end
            WAIT_R: begin
                if (mem_rvalid || timeout) begin
                    next_state = RESP;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: which pulse, error and read-data update accompany the move into RESP
    always_comb begin
        set_error     = 1'b0;
        pulse_rd_next = 1'b0;
        pulse_wr_next = 1'b0;
        load_rdata    = 1'b0;
        rdata_next    = ERR_RDATA;
        case (state)
            IDLE: begin
                if (bad_request) begin
                    set_error     = 1'b1;
                    pulse_rd_next = memory_read_enable;
                    pulse_wr_next = memory_write_enable;
                    load_rdata    = memory_read_enable;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    pulse_wr_next = mem_we;
                end else if (timeout) begin
                    set_error     = 1'b1;
                    pulse_rd_next = ~mem_we;
                    pulse_wr_next = mem_we;
                    load_rdata    = ~mem_we;
                end
            end
            WAIT_R: begin
                if (mem_rvalid) begin
                    pulse_rd_next = 1'b1;
                    load_rdata    = 1'b1;
                    rdata_next    = mem_rdata;
                end else if (timeout) begin
                    set_error     = 1'b1;
                    pulse_rd_next = 1'b1;
                    load_rdata    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Registered outputs; bus fields are latched once at request acceptance and held stable
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req                <= 1'b0;
            mem_we                 <= 1'b0;
            mem_addr               <= '0;
            mem_wdata              <= '0;
            memory_read_data       <= '0;
            memory_read_data_valid <= 1'b0;
            memory_write_done      <= 1'b0;
            mau_error              <= 1'b0;
            mau_busy               <= 1'b0;
        end else begin
            mem_req                <= (next_state == REQ);
            mau_busy               <= (next_state != IDLE);
            memory_read_data_valid <= pulse_rd_next;
            memory_write_done      <= pulse_wr_next;
            if (set_error) begin
                mau_error <= 1'b1;
            end
            if (load_rdata) begin
                memory_read_data <= rdata_next;
            end
            if (state == IDLE && good_request) begin
                mem_we    <= memory_write_enable;
                mem_addr  <= memory_address[MEM_ADDR_W+1:2];
                mem_wdata <= memory_write_data;
            end
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - self-checking bench for memory_access_unit
module tb_memory_access_unit;

    localparam logic [31:0] ERR = 32'hDEAD_BEEF;
    localparam int          TO  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_read_enable;
    logic        memory_write_enable;
    logic [31:0] memory_address;
    logic [31:0] memory_write_data;
    logic [31:0] memory_read_data;
    logic        memory_read_data_valid;
    logic        memory_write_done;
    logic        mem_req;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mau_error;
    logic        mau_busy;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata;
    logic        exp_err;

    memory_access_unit dut (
        .clk                    (clk),
        .reset                  (reset),
        .memory_read_enable     (memory_read_enable),
        .memory_write_enable    (memory_write_enable),
        .memory_address         (memory_address),
        .memory_write_data      (memory_write_data),
        .memory_read_data       (memory_read_data),
        .memory_read_data_valid (memory_read_data_valid),
        .memory_write_done      (memory_write_done),
        .mem_req                (mem_req),
        .mem_we                 (mem_we),
        .mem_addr               (mem_addr),
        .mem_wdata              (mem_wdata),
        .mem_gnt                (mem_gnt),
        .mem_rvalid             (mem_rvalid),
        .mem_rdata              (mem_rdata),
        .mau_error              (mau_error),
        .mau_busy               (mau_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One complete request seen from the requester side, with the bench acting as backing memory.
    // gd = cycles mem_req is held before gnt (-1 = never), rd_d = extra cycles between gnt and rvalid.
    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int gd, input int rd_d,
                          input logic [31:0] rdv);
        logic bad;
        logic to;
        int   lat_exp;
        int   req_exp;
        int   req_cnt;
        int   gnt_t;
        int   limit;
        bit   done;
        bad     = (rd && wr) || (addr[1:0] != 2'b00);
        to      = !bad && (gd < 0);
        lat_exp = bad ? 1 : (to ? TO + 1 : (wr ? 2 + gd : 3 + gd + rd_d));
        req_exp = bad ? 0 : (to ? TO : gd + 1);
        limit   = lat_exp + 3;
        req_cnt = 0;
        gnt_t   = -1;
        done    = 0;
        @(negedge clk);
        memory_read_enable  = rd;
        memory_write_enable = wr;
        memory_address      = addr;
        memory_write_data   = wd;
        for (int t = 1; t <= limit && !done; t++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (bad) begin
                chk("no_bus_on_error", {31'd0, mem_req}, 32'd0);
            end
            if (mem_req) begin
                chk("mem_addr", {2'b00, mem_addr}, {2'b00, addr[31:2]});
                chk("mem_we", {31'd0, mem_we}, {31'd0, wr});
                if (wr) chk("mem_wdata", mem_wdata, wd);
                if (gd >= 0 && req_cnt == gd) begin
                    mem_gnt = 1'b1;
                    gnt_t   = t;
                end
                req_cnt++;
                mem_rvalid = 1'($urandom_range(0, 1));
            end else if (rd && !wr && gnt_t > 0 && t == gnt_t + 1 + rd_d) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rdv;
            end
            if (memory_read_data_valid || memory_write_done) begin
                done = 1;
                if (bad || to) exp_err = 1'b1;
                if (rd) exp_rdata = (bad || to) ? ERR : rdv;
                chk("latency", t, lat_exp);
                chk("valid_pulse", {31'd0, memory_read_data_valid}, {31'd0, rd});
                chk("done_pulse", {31'd0, memory_write_done}, {31'd0, wr});
                chk("busy_in_resp", {31'd0, mau_busy}, 32'd1);
                chk("rdata_at_pulse", memory_read_data, exp_rdata);
                chk("error_at_pulse", {31'd0, mau_error}, {31'd0, exp_err});
                memory_read_enable  = 1'b0;
                memory_write_enable = 1'b0;
            end
        end
        chk("pulse_seen", {31'd0, done}, 32'd1);
        chk("req_cycles", req_cnt, req_exp);
        memory_read_enable  = 1'b0;
        memory_write_enable = 1'b0;
        @(negedge clk);
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        chk("pulse_single", {30'd0, memory_read_data_valid, memory_write_done}, 32'd0);
        chk("idle_not_busy", {31'd0, mau_busy}, 32'd0);
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("rdata_held", memory_read_data, exp_rdata);
            chk("idle_quiet", {28'd0, mem_req, memory_read_data_valid, memory_write_done, mau_busy}, 32'd0);
            chk("error_sticky", {31'd0, mau_error}, {31'd0, exp_err});
        end
    endtask

    initial begin
        logic [31:0] a;
        int          kind;
        reset               = 1'b1;
        memory_read_enable  = 1'b0;
        memory_write_enable = 1'b0;
        memory_address      = '0;
        memory_write_data   = '0;
        mem_gnt             = 1'b0;
        mem_rvalid          = 1'b0;
        mem_rdata           = '0;
        exp_rdata           = '0;
        exp_err             = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {26'd0, mem_req, mem_we, memory_read_data_valid, memory_write_done,
                              mau_error, mau_busy}, 32'd0);
        chk("reset_rdata", memory_read_data, 32'd0);
        chk("reset_addr", {2'b00, mem_addr}, 32'd0);
        chk("reset_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        // Directed write and read from the plan
        access(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 0, 0, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0020, 32'h0, 3, 1, 32'hCAFE_F00D);
        chk("read_plan_data", memory_read_data, 32'hCAFE_F00D);
        idle_check(5);
        access(1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 1, 0, 32'h0);
        idle_check(1);

        // Reset while waiting for rvalid, then a stray rvalid
        @(negedge clk);
        memory_read_enable = 1'b1;
        memory_address     = 32'h0000_0030;
        @(negedge clk);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt            = 1'b0;
        memory_read_enable = 1'b0;
        chk("wait_r_busy", {30'd0, mau_busy, mem_req}, 32'd2);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        exp_rdata  = 32'd0;
        exp_err    = 1'b0;
        chk("after_reset_rdata", memory_read_data, 32'd0);
        chk("after_reset_quiet", {28'd0, mem_req, memory_read_data_valid, memory_write_done, mau_busy}, 32'd0);
        idle_check(2);
        access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 0, 0, 32'h7777_0001);

        // Random legal traffic: error flag must stay clear
        for (int i = 0; i < 20; i++) begin
            a    = $urandom;
            a    = {a[31:2], 2'b00};
            kind = $urandom_range(0, 1);
            access(kind == 1, kind == 0, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            idle_check($urandom_range(0, 2));
        end

        // Misaligned read and conflicting request
        access(1'b1, 1'b0, 32'h0000_0022, 32'h0, 0, 0, 32'h0);
        chk("misaligned_rdata", memory_read_data, ERR);
        idle_check(2);
        access(1'b1, 1'b1, 32'h0000_0000, 32'h1111_2222, 0, 0, 32'h0);

        // Random mixed traffic including errors
        for (int i = 0; i < 20; i++) begin
            a    = $urandom;
            kind = $urandom_range(0, 4);
            if (kind < 2) a = {a[31:2], 2'b00};
            else if (kind < 4) a = {a[31:2], 2'($urandom_range(1, 3))};
            access(kind != 1, kind == 1 || kind == 4, a, $urandom, $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom);
        end

`ifdef MAU_TIMEOUT_EN
        access(1'b1, 1'b0, 32'h0000_0040, 32'h0, -1, 0, 32'h0);
        access(1'b0, 1'b1, 32'h0000_0048, 32'h9999_0000, -1, 0, 32'h0);
`endif

        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        exp_err   = 1'b0;
        exp_rdata = 32'd0;
        idle_check(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Responder end of the control unit's memory handshake. It accepts level-held read/write requests and pulses read-data-valid or write-done when the access finishes.
- It translates each request into a single word access on a simple req/gnt/rvalid backing-memory bus.
- It holds read data stable after completion, so the control unit's write-back stage can consume it combinationally.
- It detects misaligned and conflicting requests without touching the bus.

Parameters:
- MEM_ADDR_W, 30, width of word address on backing bus; mem_addr = memory_address[MEM_ADDR_W+1:2]
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with MAU_TIMEOUT_EN); legal range 2..65535
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on any error response

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- memory_read_enable  in  1  read request, held high by requester until memory_read_data_valid is seen
- memory_write_enable  in  1  write request, held high by requester until memory_write_done is seen
- memory_address  in  32  byte address, must be word aligned
- memory_write_data  in  32  write data
- memory_read_data  out  32  read data, registered, held until next read completes
- memory_read_data_valid  out  1  one-cycle completion pulse for reads
- memory_write_done  out  1  one-cycle completion pulse for writes
- mem_req  out  1  backing-bus request, held until mem_gnt
- mem_we  out  1  1 = write, 0 = read; stable while mem_req high
- mem_addr  out  MEM_ADDR_W  word address
- mem_wdata  out  32  write data
- mem_gnt  in  1  bus accepts request this cycle; a write is complete on gnt
- mem_rvalid  in  1  read data valid, earliest the cycle after gnt
- mem_rdata  in  32  read data
- mau_error  out  1  sticky error flag, cleared only by reset
- mau_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sampled at clk edge, reset=1):
  - state = IDLE.
  - Outputs mem_req, mem_we, memory_read_data_valid, memory_write_done, mau_error and mau_busy are 0.
  - memory_read_data, mem_addr and mem_wdata are 0.
  - Reset mid-access abandons the access with no pulse. Any later mem_rvalid is ignored until a new read reaches WAIT_R.
- States: IDLE, REQ, WAIT_R, RESP. All outputs are registered.
- IDLE:
  - Exactly one enable high and address aligned: latch address and data, set mem_we = write, go to REQ (mem_req=1 next cycle).
  - memory_address[1:0] != 0: no bus access, set mau_error, go to RESP. Reads return ERR_RDATA.
  - Both enables high: no bus access, set mau_error, go to RESP. Both pulses fire, and memory_read_data = ERR_RDATA.
- REQ:
  - mem_req held with stable addr, we and wdata until mem_gnt.
  - Write with gnt: go to RESP.
  - Read with gnt: drop mem_req, go to WAIT_R.
- WAIT_R: on mem_rvalid, capture mem_rdata into memory_read_data and go to RESP.
- RESP:
  - Exactly one of memory_read_data_valid or memory_write_done is high for one cycle (both high only in the conflict case).
  - Next state is IDLE.
- Latency, measured from the first cycle the enable is high, with gnt immediate:
  - Write: done pulse 2 cycles later.
  - Read: valid pulse 3 cycles later when rvalid follows gnt by 1 cycle; each extra wait cycle adds one.
- Requests are ignored outside IDLE. An enable still high in the cycle after a pulse is taken as a new request; the requester deasserts on the pulse edge.
- Stray mem_rvalid in IDLE, REQ or RESP is ignored.
- memory_read_data changes only at read completion or on an error read response.

Optional Feature:
- Macro: MAU_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to REQ or WAIT_R and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES: drop mem_req, set mau_error, go to RESP with the normal pulse. Reads return ERR_RDATA.
  - A late rvalid or gnt after a timeout is ignored.
- When undefined: no counter; the unit waits indefinitely in REQ or WAIT_R.

Test Plan:
- Aligned write, addr 0x0000_0010, data 0x1234_5678, gnt immediate -> mem_addr = 0x4, mem_we = 1, mem_wdata = 0x12345678; single memory_write_done pulse 2 cycles after enable; mau_error = 0.
- Aligned read, addr 0x0000_0020, gnt after 3 cycles, rvalid 2 cycles later with 0xCAFE_F00D -> single valid pulse; memory_read_data = 0xCAFEF00D, held through 5 idle cycles and a following write.
- Read at addr 0x0000_0022 -> no mem_req ever; valid pulse with data 0xDEADBEEF; mau_error = 1 and stays 1 until reset.
- Both enables high at addr 0x0 -> no bus access; both pulses in the same cycle; mau_error = 1.
- Reset asserted while in WAIT_R, followed by a stray rvalid -> no pulse; state IDLE; memory_read_data = 0; next read completes normally.
- With MAU_TIMEOUT_EN and TIMEOUT_CYCLES = 8, gnt never asserted -> mem_req drops after 8 cycles; valid pulse with 0xDEADBEEF; mau_error = 1.
